// File: rtl/warp_xwb_pkg.sv
// Shared types and constants for the scalar integer writeback collector.
package warp_xwb_pkg;

    localparam int XLEN    = 64;
    localparam int REG_W   = 5;
    localparam int ENTRY_W = REG_W + XLEN;

    // One queued result: destination register plus the value to write.
    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  data;
    } wb_entry_t;

    // Modulo-n increment used to advance the round-robin pointer.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/warp_xwb_fifo.sv
// Per-source result queue. Pointers carry an extra wrap bit so a full
// queue can be told apart from an empty one.
module warp_xwb_fifo
    import warp_xwb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_next;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign head  = mem[rptr[AW-1:0]];

    // A push into a full queue still fits when the head leaves in the same cycle.
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);

    // Advance pointers and register the early-warning flag from the post-edge count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr        <= '0;
            rptr        <= '0;
            almost_full <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            almost_full <= (count_next >= (AW+1)'(DEPTH - 1));
        end
    end

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/warp_xwb.sv
// Writeback collector: per-source queues, a two-port round-robin arbiter
// that never pairs equal destinations, and registered write ports.
module warp_xwb
    import warp_xwb_pkg::*;
#(
    parameter int NSRC  = 4,
    parameter int DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NSRC-1:0]       i_valid,
    input  logic [REG_W*NSRC-1:0] i_rd,
    input  logic [XLEN*NSRC-1:0]  i_data,
    output logic [NSRC-1:0]       o_almost_full,
    output logic                  o_overflow,
    output logic                  o_rd1_wen,
    output logic [REG_W-1:0]      o_rd1_addr,
    output logic [XLEN-1:0]       o_rd1_wdata,
    output logic                  o_rd2_wen,
    output logic [REG_W-1:0]      o_rd2_addr,
    output logic [XLEN-1:0]       o_rd2_wdata,
    output logic                  o_idle
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int RRW = (NSRC > 1) ? $clog2(NSRC) : 1;

    wb_entry_t       head  [NSRC];
    logic [CW-1:0]   count [NSRC];
    logic [NSRC-1:0] empty;
    logic [NSRC-1:0] full;
    logic [NSRC-1:0] pop;

    logic [RRW-1:0]  rr;
    logic [RRW-1:0]  rr_next;
    logic [RRW-1:0]  sel;
    logic [RRW-1:0]  g1_idx;
    logic [RRW-1:0]  g2_idx;
    logic            g1_found;
    logic            g2_found;
    wb_entry_t       g1_entry;
    wb_entry_t       g2_entry;
    logic            drop;
    logic            any_queued;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        warp_xwb_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (ENTRY_W)
        ) u_fifo (
            .clk         (i_clk),
            .rst_n       (i_rst_n),
            .push        (i_valid[s]),
            .pop         (pop[s]),
            .wdata       ({i_rd[REG_W*s +: REG_W], i_data[XLEN*s +: XLEN]}),
            .head        (head[s]),
            .empty       (empty[s]),
            .full        (full[s]),
            .count       (count[s]),
            .almost_full (o_almost_full[s])
        );
    end

    // Scan from rr: first ready head takes port 1, next head with a different rd takes port 2.
    always_comb begin
        g1_found = 1'b0;
        g2_found = 1'b0;
        g1_idx   = '0;
        g2_idx   = '0;
        g1_entry = '0;
        g2_entry = '0;
        sel      = '0;
        pop      = '0;
        rr_next  = rr;
        for (int k = 0; k < NSRC; k++) begin
            sel = RRW'((int'(rr) + k) % NSRC);
            if (!empty[sel]) begin
                if (!g1_found) begin
                    g1_found = 1'b1;
                    g1_idx   = sel;
                    g1_entry = head[sel];
                end else if (!g2_found && (head[sel].rd != g1_entry.rd)) begin
                    g2_found = 1'b1;
                    g2_idx   = sel;
                    g2_entry = head[sel];
                end
            end
        end
        if (g1_found) begin
            pop[g1_idx] = 1'b1;
            rr_next     = RRW'(wrap_inc(int'(g1_idx), NSRC));
        end
        if (g2_found) begin
            pop[g2_idx] = 1'b1;
            rr_next     = RRW'(wrap_inc(int'(g2_idx), NSRC));
        end
    end

    // A push is lost only when its queue is full and its head is not leaving.
    assign drop = |(i_valid & full & ~pop);

    // Idle means nothing queued anywhere and no write presented to the register file.
    always_comb begin
        any_queued = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            any_queued = any_queued | (count[s] != '0);
        end
    end

    assign o_idle = !any_queued && !o_rd1_wen && !o_rd2_wen;

    // Register the granted heads onto the write ports; x0 occupies a slot but never writes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr          <= '0;
            o_overflow  <= 1'b0;
            o_rd1_wen   <= 1'b0;
            o_rd1_addr  <= '0;
            o_rd1_wdata <= '0;
            o_rd2_wen   <= 1'b0;
            o_rd2_addr  <= '0;
            o_rd2_wdata <= '0;
        end else begin
            rr <= rr_next;
            if (drop) o_overflow <= 1'b1;
            o_rd1_wen <= g1_found && (g1_entry.rd != '0);
            o_rd2_wen <= g2_found && (g2_entry.rd != '0);
            if (g1_found) begin
                o_rd1_addr  <= g1_entry.rd;
                o_rd1_wdata <= g1_entry.data;
            end
            if (g2_found) begin
                o_rd2_addr  <= g2_entry.rd;
                o_rd2_wdata <= g2_entry.data;
            end
        end
    end

endmodule

// File: tb/tb_warp_xwb.sv
// Directed self-checking bench for the writeback collector.
module tb_warp_xwb;

    logic          i_clk;
    logic          i_rst_n;
    logic [3:0]    i_valid;
    logic [19:0]   i_rd;
    logic [255:0]  i_data;
    logic [3:0]    o_almost_full;
    logic          o_overflow;
    logic          o_rd1_wen;
    logic [4:0]    o_rd1_addr;
    logic [63:0]   o_rd1_wdata;
    logic          o_rd2_wen;
    logic [4:0]    o_rd2_addr;
    logic [63:0]   o_rd2_wdata;
    logic          o_idle;

    int checks = 0;
    int errors = 0;

    warp_xwb #(
        .NSRC  (4),
        .DEPTH (4)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_rd          (i_rd),
        .i_data        (i_data),
        .o_almost_full (o_almost_full),
        .o_overflow    (o_overflow),
        .o_rd1_wen     (o_rd1_wen),
        .o_rd1_addr    (o_rd1_addr),
        .o_rd1_wdata   (o_rd1_wdata),
        .o_rd2_wen     (o_rd2_wen),
        .o_rd2_addr    (o_rd2_addr),
        .o_rd2_wdata   (o_rd2_wdata),
        .o_idle        (o_idle)
    );

    // Free-running clock, period 10.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_valid = '0;
        i_rd    = '0;
        i_data  = '0;
    endtask

    task automatic push(input int s, input logic [4:0] rd, input logic [63:0] data);
        i_valid[s]        = 1'b1;
        i_rd[5*s +: 5]    = rd;
        i_data[64*s +: 64] = data;
    endtask

    task automatic apply_reset();
        clear_inputs();
        i_rst_n = 1'b0;
        step();
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst_n = 1'b0;
        #3;
        checks++;
        if ({o_rd1_wen, o_rd2_wen, o_rd1_addr, o_rd2_addr, o_rd1_wdata, o_rd2_wdata,
             o_almost_full, o_overflow, o_idle} !== {2'b00, 10'd0, 128'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_state: got wen=%b%b af=%h ovf=%b idle=%b addr=%h/%h, expected all zero with idle=1",
                     o_rd1_wen, o_rd2_wen, o_almost_full, o_overflow, o_idle, o_rd1_addr, o_rd2_addr);
        end
        step();
        i_rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        push(0, 5'd5, 64'h1234);
        step();
        clear_inputs();
        checks++;
        if ({o_rd1_wen, o_idle} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL single_c1: got wen1=%b idle=%b, expected wen1=0 idle=0", o_rd1_wen, o_idle);
        end
        step();
        checks++;
        if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen} !== {1'b1, 5'd5, 64'h1234, 1'b0}) begin
            errors++;
            $display("[TB] FAIL single_c2: got wen1=%b addr=%0d data=%h wen2=%b, expected 1 5 1234 0",
                     o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen);
        end
        step();
        checks++;
        if ({o_idle, o_rd1_wen} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL single_c3: got idle=%b wen1=%b, expected idle=1 wen1=0", o_idle, o_rd1_wen);
        end
    endtask

    task automatic test_dual();
        apply_reset();
        push(0, 5'd3, 64'hA);
        push(1, 5'd4, 64'hB);
        step();
        clear_inputs();
        step();
        checks++;
        if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata} !==
            {1'b1, 5'd3, 64'hA, 1'b1, 5'd4, 64'hB}) begin
            errors++;
            $display("[TB] FAIL dual: got p1=%b/%0d/%h p2=%b/%0d/%h, expected p1=1/3/a p2=1/4/b",
                     o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata);
        end
    endtask

    task automatic test_same_rd();
        apply_reset();
        push(2, 5'd7, 64'hAAAA);
        push(3, 5'd7, 64'hBBBB);
        step();
        clear_inputs();
        step();
        checks++;
        if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen} !== {1'b1, 5'd7, 64'hAAAA, 1'b0}) begin
            errors++;
            $display("[TB] FAIL same_rd_first: got wen1=%b addr=%0d data=%h wen2=%b, expected 1 7 aaaa 0",
                     o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen);
        end
        step();
        checks++;
        if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen} !== {1'b1, 5'd7, 64'hBBBB, 1'b0}) begin
            errors++;
            $display("[TB] FAIL same_rd_second: got wen1=%b addr=%0d data=%h wen2=%b, expected 1 7 bbbb 0",
                     o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen);
        end
        step();
        checks++;
        if ({o_rd1_wen, o_rd2_wen, o_idle} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL same_rd_done: got wen=%b%b idle=%b, expected wen=00 idle=1",
                     o_rd1_wen, o_rd2_wen, o_idle);
        end
    endtask

    task automatic test_x0();
        apply_reset();
        push(0, 5'd0, 64'hDEAD);
        push(1, 5'd6, 64'h66);
        step();
        clear_inputs();
        step();
        checks++;
        if ({o_rd1_wen, o_rd2_wen, o_rd2_addr, o_rd2_wdata} !== {1'b0, 1'b1, 5'd6, 64'h66}) begin
            errors++;
            $display("[TB] FAIL x0_slot: got wen1=%b wen2=%b addr2=%0d data2=%h, expected 0 1 6 66",
                     o_rd1_wen, o_rd2_wen, o_rd2_addr, o_rd2_wdata);
        end
    endtask

    // Sources 1 and 2 keep rr parked at 2; source 0 shares rd 9 with source 2 so it starves.
    task automatic test_full_overflow();
        apply_reset();
        push(1, 5'd1, 64'h1000);
        step();
        for (int c = 1; c <= 5; c++) begin
            if (c == 3) begin
                checks++;
                if (o_almost_full[0] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL af_before: got %b expected 0", o_almost_full[0]);
                end
            end
            if (c == 4) begin
                checks++;
                if (o_almost_full[0] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL af_at_three: got %b expected 1", o_almost_full[0]);
                end
            end
            if (c == 5) begin
                checks++;
                if (o_overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL ovf_before: got %b expected 0", o_overflow);
                end
            end
            clear_inputs();
            push(0, 5'd9, 64'h900 + 64'(c - 1));
            push(1, 5'd1, 64'h1000 + 64'(c));
            push(2, 5'd9, 64'h2000 + 64'(c));
            step();
        end
        clear_inputs();
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_set: got %b expected 1", o_overflow);
        end
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen} !== {1'b1, 5'd9, 64'h900 + 64'(k), 1'b0}) begin
                errors++;
                $display("[TB] FAIL drain_%0d: got wen1=%b addr=%0d data=%h wen2=%b, expected 1 9 %h 0",
                         k, o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, 64'h900 + 64'(k));
            end
            step();
        end
        checks++;
        if ({o_rd1_wen, o_rd2_wen, o_idle, o_overflow} !== 4'b0011) begin
            errors++;
            $display("[TB] FAIL drain_end: got wen=%b%b idle=%b ovf=%b, expected wen=00 idle=1 ovf=1",
                     o_rd1_wen, o_rd2_wen, o_idle, o_overflow);
        end
    endtask

    task automatic test_fairness();
        logic [4:0]  e1_rd, e2_rd;
        logic [63:0] e1_data, e2_data;
        int          a, n;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            if (c >= 2) begin
                a = ((c - 2) % 2 == 0) ? 0 : 2;
                n = (c - 2) / 2;
                e1_rd   = 5'(10 + a);
                e2_rd   = 5'(11 + a);
                e1_data = 64'(256 * a + n);
                e2_data = 64'(256 * (a + 1) + n);
                checks++;
                if ({o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata} !==
                    {1'b1, e1_rd, e1_data, 1'b1, e2_rd, e2_data}) begin
                    errors++;
                    $display("[TB] FAIL fair_c%0d: got p1=%b/%0d/%h p2=%b/%0d/%h, expected p1=1/%0d/%h p2=1/%0d/%h",
                             c, o_rd1_wen, o_rd1_addr, o_rd1_wdata, o_rd2_wen, o_rd2_addr, o_rd2_wdata,
                             e1_rd, e1_data, e2_rd, e2_data);
                end
            end
            if (c == 7) begin
                checks++;
                if (o_overflow !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL fair_ovf_before: got %b expected 0", o_overflow);
                end
            end
            for (int s = 0; s < 4; s++) begin
                push(s, 5'(10 + s), 64'(256 * s + c));
            end
            step();
        end
        clear_inputs();
        checks++;
        if (o_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fair_ovf_after: got %b expected 1", o_overflow);
        end
    endtask

    // Follows test_fairness directly, so queues are full and ports are busy.
    task automatic test_reset_midop();
        clear_inputs();
        #3;
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rd1_wen, o_rd2_wen, o_rd1_addr, o_rd2_addr, o_rd1_wdata, o_rd2_wdata,
             o_almost_full, o_overflow, o_idle} !== {2'b00, 10'd0, 128'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL midop_reset: got wen=%b%b af=%h ovf=%b idle=%b, expected wen=00 af=0 ovf=0 idle=1",
                     o_rd1_wen, o_rd2_wen, o_almost_full, o_overflow, o_idle);
        end
        step();
        i_rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if ({o_rd1_wen, o_rd2_wen, o_idle} !== 3'b001) begin
                errors++;
                $display("[TB] FAIL post_reset_%0d: got wen=%b%b idle=%b, expected wen=00 idle=1",
                         k, o_rd1_wen, o_rd2_wen, o_idle);
            end
        end
    endtask

    // Run each scenario in turn, then report.
    initial begin
        clear_inputs();
        i_rst_n = 1'b1;
        #2;
        test_reset();
        test_single();
        test_dual();
        test_same_rd();
        test_x0();
        test_full_overflow();
        test_fairness();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
